fft_addr_sequencer: RTL and testbench

FFT_ADDR_SEQUENCER -- requirements
Module: fft_addr_sequencer

---
 rtl/fft_addr_sequencer_pkg.sv | 16 +
 rtl/fft_rotl5.sv | 10 +
 rtl/fft_addr_sequencer.sv | 112 +++++++++++
 tb/tb_fft_addr_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_addr_sequencer_pkg.sv
// fft_addr_sequencer_pkg: shared FFT constants, sequencer state type and twiddle-index helper
package fft_addr_sequencer_pkg;
  localparam int N_POINTS = 32;
  localparam int LOG2N = 5;
  localparam int ADDR_W = 5;
  localparam int TW_W = 4;
  localparam int J_W = 4;
  localparam int S_W = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;
  // Low s bits of the operand address, scaled up to the 16-entry twiddle ROM.
  function automatic logic [TW_W-1:0] tw_of(input logic [ADDR_W-1:0] a, input logic [S_W-1:0] s);
    logic [ADDR_W-1:0] m;
    m = a & ((ADDR_W'(1) << s) - ADDR_W'(1));
    return TW_W'(m << (3'd4 - s));
  endfunction
endpackage

// File: rtl/fft_rotl5.sv
// fft_rotl5: combinational 5-bit rotate-left
module fft_rotl5 (
  input  logic [4:0] din,
  input  logic [2:0] sh,
  output logic [4:0] dout
);
  logic [9:0] dbl;
  assign dbl = {din, din} << sh;
  assign dout = dbl[9:5];
endmodule

// File: rtl/fft_addr_sequencer.sv
// fft_addr_sequencer: butterfly address/twiddle sequencer for a 32-point radix-2 FFT
module fft_addr_sequencer
  import fft_addr_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              abort,
  input  logic              bf_ready,
  output logic              bf_valid,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [TW_W-1:0]   tw_idx,
  output logic [S_W-1:0]    stage,
  output logic              busy,
  output logic              done
);
  localparam int DC_W = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);
  state_e            state_q, state_d;
  logic [J_W-1:0]    j_q, j_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [DC_W-1:0]   dcnt_q, dcnt_d;
  logic              bf_valid_q, bf_valid_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, rot_a, rot_b;
  logic [TW_W-1:0]   tw_idx_q, tw_idx_d;
  logic [S_W-1:0]    stage_q, stage_d;
  logic              busy_q, busy_d, done_q, done_d;
  // Outputs are registered, so the rotators work on the next-cycle counters.
  fft_rotl5 u_rot_a (.din({j_d, 1'b0}), .sh(s_d), .dout(rot_a));
  fft_rotl5 u_rot_b (.din({j_d, 1'b1}), .sh(s_d), .dout(rot_b));
  always_comb begin
    state_d = state_q;
    j_d = j_q;
    s_d = s_q;
    dcnt_d = dcnt_q;
    if (abort) begin
      state_d = IDLE;
      j_d = '0;
      s_d = '0;
      dcnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = ISSUE;
          j_d = '0;
          s_d = '0;
        end
        ISSUE: if (bf_ready) begin
          j_d = j_q + 4'd1;
          if (j_q == 4'd15) begin
            if (s_q == S_W'(LOG2N - 1)) state_d = FINISH;
            else if (DRAIN_CYCLES == 0) s_d = s_q + 3'd1;
            else begin
              state_d = DRAIN;
              dcnt_d = '0;
            end
          end
        end
        DRAIN: if (dcnt_q == DC_LAST) begin
          state_d = ISSUE;
          s_d = s_q + 3'd1;
        end else dcnt_d = dcnt_q + DC_W'(1);
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    bf_valid_d = state_d == ISSUE;
    addr_a_d = bf_valid_d ? rot_a : '0;
    addr_b_d = bf_valid_d ? rot_b : '0;
    tw_idx_d = bf_valid_d ? tw_of(rot_a, s_d) : '0;
    stage_d = bf_valid_d ? s_d : '0;
    busy_d = state_d != IDLE;
    done_d = state_d == FINISH;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      j_q <= '0;
      s_q <= '0;
      dcnt_q <= '0;
      bf_valid_q <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_idx_q <= '0;
      stage_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q <= j_d;
      s_q <= s_d;
      dcnt_q <= dcnt_d;
      bf_valid_q <= bf_valid_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_idx_q <= tw_idx_d;
      stage_q <= stage_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bf_valid = bf_valid_q;
  assign addr_a = addr_a_q;
  assign addr_b = addr_b_q;
  assign tw_idx = tw_idx_q;
  assign stage = stage_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_fft_addr_sequencer.sv
// tb_fft_addr_sequencer: scoreboard bench for the FFT butterfly address sequencer
module tb_fft_addr_sequencer;
  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [3:0] tw;
    logic [2:0] st;
  } exp_t;
  logic clk, clr_n, start, abort, bf_ready;
  logic bf_valid, busy, done;
  logic [4:0] addr_a, addr_b;
  logic [3:0] tw_idx;
  logic [2:0] stage;
  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int xfer_total = 0;
  int xfer_base = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int sp_s[4] = '{0, 1, 2, 4};
  int sp_j[4] = '{5, 5, 8, 7};
  int sp_a[4] = '{10, 20, 2, 7};
  int sp_b[4] = '{11, 22, 6, 23};
  int sp_t[4] = '{0, 0, 8, 7};

  fft_addr_sequencer #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .abort(abort), .bf_ready(bf_ready),
    .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx),
    .stage(stage), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Butterfly idx of a transform: bit k of {j,0} lands at bit (k+s) mod 5.
  function automatic exp_t model(input int idx);
    int s;
    int j;
    logic [4:0] in_v;
    logic [4:0] a;
    exp_t e;
    s = idx / 16;
    j = idx % 16;
    in_v = 5'(j * 2);
    a = '0;
    for (int k = 0; k < 5; k++) a[(k + s) % 5] = in_v[k];
    e.a = a;
    e.b = a | 5'(1 << s);
    e.tw = 4'((int'(a) % (1 << s)) << (4 - s));
    e.st = 3'(s);
    return e;
  endfunction

  always @(negedge clk) begin
    if (clr_n) begin
      if (bf_valid && bf_ready) begin
        int n;
        exp_t e;
        xfer_total++;
        n = xfer_total - xfer_base - 1;
        if (exp_q.size() == 0) check("unexpected_xfer", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_addr_a", int'(addr_a), int'(e.a));
          check("sb_addr_b", int'(addr_b), int'(e.b));
          check("sb_tw_idx", int'(tw_idx), int'(e.tw));
          check("sb_stage", int'(stage), int'(e.st));
        end
        for (int i = 0; i < 4; i++)
          if (n == sp_s[i] * 16 + sp_j[i]) begin
            check("spot_addr_a", int'(addr_a), sp_a[i]);
            check("spot_addr_b", int'(addr_b), sp_b[i]);
            check("spot_tw_idx", int'(tw_idx), sp_t[i]);
          end
      end else if (!bf_valid) check("idle_outputs_zero", int'({addr_a, addr_b, tw_idx, stage}), 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    xfer_base = xfer_total;
    for (int i = 0; i < 80; i++) exp_q.push_back(model(i));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_xfer(input int n);
    int i;
    for (i = 0; i < 300 && xfer_total - xfer_base != n; i++) begin
      @(posedge clk);
      #1;
    end
    if (xfer_total - xfer_base != n) check("wait_xfer_timeout", xfer_total - xfer_base, n);
  endtask

  task automatic wait_done(input string name, input int delay);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) check({name, "_timeout"}, 0, 1);
    else check({name, "_done_cycle"}, done_cyc - start_cyc, delay);
    check({name, "_xfers"}, xfer_total - xfer_base, 80);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_done_width"}, int'(done), 0);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_done_count"}, done_cnt, d0 + 1);
  endtask

  initial begin
    int d0;
    clr_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bf_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({bf_valid, busy, done, addr_a, addr_b, tw_idx, stage}), 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // full transform, ready always high
    pulse_start();
    wait_done("basic", 93);

    // stall three cycles on s=2, j=9
    pulse_start();
    wait_xfer(41);
    check("stall_valid_pre", int'(bf_valid), 1);
    bf_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", int'(bf_valid), 1);
      check("stall_addr_a", int'(addr_a), 10);
      check("stall_addr_b", int'(addr_b), 14);
      check("stall_tw_idx", int'(tw_idx), 8);
      check("stall_stage", int'(stage), 2);
      check("stall_xfers", xfer_total - xfer_base, 41);
    end
    @(posedge clk);
    #1;
    bf_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_resume_xfers", xfer_total - xfer_base, 42);
    wait_done("stall", 96);

    // abort in the drain after stage 1
    pulse_start();
    wait_xfer(32);
    check("abort_in_drain_valid", int'(bf_valid), 0);
    check("abort_in_drain_busy", int'(busy), 1);
    d0 = done_cnt;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(bf_valid), 0);
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt, d0);
    check("abort_left", exp_q.size(), 48);
    exp_q.delete();
    pulse_start();
    @(negedge clk);
    check("restart_addr_a", int'(addr_a), 0);
    check("restart_addr_b", int'(addr_b), 1);
    check("restart_stage", int'(stage), 0);
    wait_done("restart", 93);

    // asynchronous reset in the middle of ISSUE
    pulse_start();
    wait_xfer(20);
    d0 = done_cnt;
    #3;
    clr_n = 1'b0;
    #1;
    check("areset_outputs", int'({bf_valid, busy, done, addr_a, addr_b, tw_idx, stage}), 0);
    #3;
    clr_n = 1'b1;
    exp_q.delete();
    repeat (8) @(negedge clk);
    check("areset_no_done", done_cnt, d0);
    check("areset_idle", int'(busy), 0);

    // start pulsed again while busy must be ignored
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", 93);
    repeat (5) @(negedge clk);
    check("busy_start_no_rerun", int'(busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
    $fatal(1);
  end
endmodule
